// File: rtl/ntt_inverse.sv
// Inverse NTT engine: PARALLEL Gentleman-Sande butterflies per cycle over an
// internal N-word register file, followed by an in-place N^-1 scaling pass.
module ntt_inverse #(
  parameter int N              = 256,
  parameter int WIDTH          = 32,
  parameter int Q              = 8380417,
  parameter int ADDR_WIDTH     = 8,
  parameter int REDUCTION_TYPE = 0,
  parameter int PARALLEL       = 8,
  parameter int N_INV          = 8347681
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  input  logic                  load_coeff,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]      load_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);
  localparam int QBITS = $clog2(Q);
  localparam logic [63:0]           ROOT       = 64'd1753; // primitive 2N-th root of unity mod Q
  localparam logic [127:0]          Q128       = 128'(Q);
  localparam logic [WIDTH-1:0]      Q_W        = WIDTH'(Q);
  localparam logic [WIDTH:0]        Q_EXT      = (WIDTH+1)'(Q);
  localparam logic [127:0]          BARRETT_MU = (128'd1 << (2 * QBITS)) / Q128;
  localparam logic [63:0]           MONT_R2    = 64'((128'd1 << 64) % Q128);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] STAGE_LAST = ADDR_WIDTH'(ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_LAST  = ADDR_WIDTH'(N / 2 - PARALLEL);
  localparam logic [ADDR_WIDTH-1:0] BASE_STEP  = ADDR_WIDTH'(PARALLEL);

  function automatic logic [31:0] mont_qneg();
    logic [31:0] x;
    x = 32'(Q);
    for (int i = 0; i < 5; i++) x = x * (32'd2 - 32'(Q) * x);
    return 32'd0 - x;
  endfunction

  localparam logic [31:0] MONT_QNEG = mont_qneg();

  function automatic logic [N-1:0][WIDTH-1:0] gen_twiddles();
    logic [N-1:0][WIDTH-1:0] t;
    logic [63:0]             acc;
    acc = 64'd1;
    for (int j = 0; j < N; j++) begin
      t[j] = WIDTH'(acc);
      acc  = (acc * ROOT) % 64'(Q);
    end
    return t;
  endfunction

  localparam logic [N-1:0][WIDTH-1:0] TWIDDLE_ROM = gen_twiddles();

  function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] v);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = v[ADDR_WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return WIDTH'((s >= Q_EXT) ? s - Q_EXT : s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? a - b : a + Q_W - b;
  endfunction

  // t < Q*2^32 gives a result below 2Q, so one correction suffices
  function automatic logic [31:0] mont_reduce(input logic [63:0] t);
    logic [31:0] m;
    logic [63:0] u;
    m = t[31:0] * MONT_QNEG;
    u = (t + 64'(m) * 64'(Q)) >> 32;
    return 32'((u >= 64'(Q)) ? u - 64'(Q) : u);
  endfunction

  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [63:0] p;
    logic [63:0] qh;
    logic [63:0] r;
    p = 64'(a) * 64'(b);
    case (REDUCTION_TYPE)
      1: begin
        qh = 64'((128'(p) * BARRETT_MU) >> (2 * QBITS));
        r  = p - qh * 64'(Q);
        r  = (r >= 64'(Q)) ? r - 64'(Q) : r;
      end
      2:       r = 64'(mont_reduce(64'(mont_reduce(p)) * MONT_R2));
      default: r = p % 64'(Q);
    endcase
    return WIDTH'(r);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] bf_addr0(input logic [ADDR_WIDTH-1:0] t,
                                                     input logic [ADDR_WIDTH-1:0] b);
    return ((b >> t) << (t + ADDR_ONE)) | (b & ((ADDR_ONE << t) - ADDR_ONE));
  endfunction

  // Inverse twiddle is the negated forward ROM entry; a zero entry stays zero
  function automatic logic [WIDTH-1:0] bf_twiddle(input logic [ADDR_WIDTH-1:0] t,
                                                  input logic [ADDR_WIDTH-1:0] b);
    logic [WIDTH-1:0] z;
    z = TWIDDLE_ROM[bit_reverse((ADDR_ONE << (STAGE_LAST - t)) + (b >> t))];
    return (z == '0) ? '0 : Q_W - z;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, SCALE = 2'd2, FIN = 2'd3} state_t;

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] stage_r, base_r;
  logic                  wrap_s;
  logic [WIDTH-1:0]      mem_r      [N];
  logic [ADDR_WIDTH-1:0] addr0_s    [PARALLEL];
  logic [ADDR_WIDTH-1:0] addr1_s    [PARALLEL];
  logic [WIDTH-1:0]      bf_a_s     [PARALLEL];
  logic [WIDTH-1:0]      bf_b_s     [PARALLEL];
  logic [ADDR_WIDTH-1:0] scl_addr_s [2*PARALLEL];
  logic [WIDTH-1:0]      scl_s      [2*PARALLEL];

  assign wrap_s = (base_r == BASE_LAST);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? COMPUTE : IDLE;
      COMPUTE: state_s = (wrap_s && stage_r == STAGE_LAST) ? SCALE : COMPUTE;
      SCALE:   state_s = wrap_s ? FIN : SCALE;
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == COMPUTE) || (state_s == SCALE);
      done    <= (state_s == FIN);
    end
  end

  // Butterfly base / stage counters; base doubles as the scale block index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r  <= '0;
      stage_r <= '0;
    end else if (state_r == COMPUTE || state_r == SCALE) begin
      base_r <= wrap_s ? '0 : base_r + BASE_STEP;
      if (state_r == COMPUTE && wrap_s) begin
        stage_r <= (stage_r == STAGE_LAST) ? '0 : stage_r + ADDR_ONE;
      end
    end else begin
      base_r  <= '0;
      stage_r <= '0;
    end
  end

  // Lane datapaths: butterflies for COMPUTE, N^-1 multipliers for SCALE
  always_comb begin
    for (int l = 0; l < PARALLEL; l++) begin
      addr0_s[l] = bf_addr0(stage_r, base_r + ADDR_WIDTH'(l));
      addr1_s[l] = addr0_s[l] + (ADDR_ONE << stage_r);
      bf_a_s[l]  = mod_add(mem_r[addr0_s[l]], mem_r[addr1_s[l]]);
      bf_b_s[l]  = mod_mul(mod_sub(mem_r[addr0_s[l]], mem_r[addr1_s[l]]),
                           bf_twiddle(stage_r, base_r + ADDR_WIDTH'(l)));
    end
    for (int k = 0; k < 2 * PARALLEL; k++) begin
      scl_addr_s[k] = (base_r << 1) + ADDR_WIDTH'(k);
      scl_s[k]      = mod_mul(mem_r[scl_addr_s[k]], WIDTH'(N_INV));
    end
  end

  // Coefficient memory: transform write-back has priority, host loads only when idle
  always_ff @(posedge clk) begin
    if (state_r == COMPUTE) begin
      for (int l = 0; l < PARALLEL; l++) begin
        mem_r[addr0_s[l]] <= bf_a_s[l];
        mem_r[addr1_s[l]] <= bf_b_s[l];
      end
    end else if (state_r == SCALE) begin
      for (int k = 0; k < 2 * PARALLEL; k++) mem_r[scl_addr_s[k]] <= scl_s[k];
    end else if (load_coeff) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Registered read port, active in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) read_data <= '0;
    else     read_data <= mem_r[read_addr];
  end
endmodule

// File: tb/tb_ntt_inverse.sv
// Bench for ntt_inverse: three instances (one per reduction style) driven in
// lockstep, checked against a reference forward transform and round trips.
module tb_ntt_inverse;
  localparam int N = 256;
  localparam int WIDTH = 32;
  localparam int Q = 8380417;
  localparam int AW = 8;
  localparam int BUSY_CYCLES = 144;
  localparam longint unsigned QL = 64'd8380417;
  localparam logic [WIDTH-1:0] Q_W = 32'd8380417;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic load_coeff = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [AW-1:0] read_addr = '0;
  logic [WIDTH-1:0] load_data = '0;
  logic [2:0] done_v, busy_v;
  logic [2:0][WIDTH-1:0] rd_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ntt_inverse #(.REDUCTION_TYPE(g)) dut (
      .clk(clk), .rst(rst), .start(start), .done(done_v[g]), .busy(busy_v[g]),
      .load_coeff(load_coeff), .load_addr(load_addr), .load_data(load_data),
      .read_addr(read_addr), .read_data(rd_v[g])
    );
  end

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nbusy;
  longint unsigned rom[N];
  longint unsigned x_ref[N];
  longint unsigned x_fwd[N];
  longint unsigned exp_v[N];

  task automatic check(input string tag, input longint unsigned got, input longint unsigned expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic longint unsigned mpow(input longint unsigned b, input longint unsigned e);
    longint unsigned r;
    r = 1;
    b = b % QL;
    while (e != 0) begin
      if (e[0]) r = (r * b) % QL;
      b = (b * b) % QL;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) if (v[i]) r = r | (1 << (AW - 1 - i));
    return r;
  endfunction

  // Reference forward transform: undoes each inverse stage (last stage first)
  // so that inverse(forward(x)) == x once the N^-1 scaling is applied.
  function automatic void make_forward();
    int half, groups, i0, i1;
    longint unsigned z, w, wi, u, v;
    for (int i = 0; i < N; i++) x_fwd[i] = x_ref[i];
    for (int t = AW - 1; t >= 0; t--) begin
      half = 1 << t;
      groups = N / (2 * half);
      for (int g = 0; g < groups; g++) begin
        z = rom[brev(groups + g)];
        w = (z == 0) ? 0 : QL - z;
        wi = mpow(w, QL - 2);
        for (int p = 0; p < half; p++) begin
          i0 = g * 2 * half + p;
          i1 = i0 + half;
          u = x_fwd[i0];
          v = (x_fwd[i1] * wi) % QL;
          x_fwd[i0] = (u + v) % QL;
          x_fwd[i1] = (u + QL - v) % QL;
        end
      end
    end
  endfunction

  task automatic load_fwd();
    for (int i = 0; i < N; i++) begin
      load_coeff = 1'b1;
      load_addr = AW'(i);
      load_data = WIDTH'(x_fwd[i]);
      @(negedge clk);
    end
    load_coeff = 1'b0;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < N; i++) begin
      read_addr = AW'(i);
      @(negedge clk);
      for (int d = 0; d < 3; d++) check($sformatf("%s[%0d] dut%0d", tag, i, d), rd_v[d], exp_v[i]);
    end
  endtask

  task automatic run(input bit disturb, input bit fin_load, output int nb);
    bit ok;
    nb = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy_v[0] && nb < 1000) begin
      nb++;
      ok = (rd_v[0] < Q_W) && (rd_v[1] < Q_W) && (rd_v[2] < Q_W);
      check("in-flight word below Q", ok, 1);
      read_addr = AW'($urandom_range(N - 1));
      start = disturb && (nb == 3 || nb == 143);
      load_coeff = disturb && (nb == 70);
      load_addr = '0;
      load_data = 32'd99;
      @(negedge clk);
    end
    start = 1'b0;
    load_coeff = 1'b0;
    check("busy length", nb, BUSY_CYCLES);
    check("done pulse", done_v, 3'b111);
    check("busy low in FIN", busy_v, 3'b000);
    if (fin_load) begin
      load_coeff = 1'b1;
      load_addr = 8'd7;
      load_data = 32'd12345;
    end
    @(negedge clk);
    load_coeff = 1'b0;
    check("done single cycle", done_v, 3'b000);
  endtask

  task automatic abort_run(input int at);
    int n;
    logic [2:0] seen;
    n = 0;
    seen = 3'b000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy_v[0] && n < at) begin
      n++;
      @(negedge clk);
    end
    check("abort reached cycle", n, at);
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy_v, 3'b000);
    check("abort done", done_v, 3'b000);
    check("abort read_data", rd_v, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (160) begin
      seen = seen | done_v | busy_v;
      @(negedge clk);
    end
    check("no activity after abort", seen, 3'b000);
  endtask

  initial begin
    for (int j = 0; j < N; j++) rom[j] = mpow(64'd1753, longint'(j));

    #2 rst = 1'b1;
    #1;
    check("reset busy", busy_v, 3'b000);
    check("reset done", done_v, 3'b000);
    check("reset read_data", rd_v, 0);
    @(negedge clk);
    rst = 1'b0;

    // All-ones input collapses to the unit impulse
    for (int i = 0; i < N; i++) begin
      x_fwd[i] = 1;
      exp_v[i] = (i == 0) ? 1 : 0;
    end
    load_fwd();
    run(1'b0, 1'b0, nbusy);
    readback("impulse");

    // Ramp round trip
    for (int i = 0; i < N; i++) x_ref[i] = longint'(i) * 1000 + 7;
    make_forward();
    load_fwd();
    run(1'b0, 1'b0, nbusy);
    for (int i = 0; i < N; i++) exp_v[i] = x_ref[i];
    readback("ramp");

    // Largest legal value everywhere
    for (int i = 0; i < N; i++) x_ref[i] = QL - 1;
    make_forward();
    load_fwd();
    run(1'b0, 1'b0, nbusy);
    for (int i = 0; i < N; i++) exp_v[i] = x_ref[i];
    readback("q_minus_1");

    // Random data with ignored start/load during the run and a load in FIN
    for (int i = 0; i < N; i++) x_ref[i] = longint'($urandom_range(Q - 1));
    if (x_ref[0] == 99) x_ref[0] = 100;
    make_forward();
    load_fwd();
    run(1'b1, 1'b1, nbusy);
    for (int i = 0; i < N; i++) exp_v[i] = x_ref[i];
    exp_v[7] = 12345;
    readback("random");

    // Abort mid-run, then a clean run from reloaded all-ones data
    for (int i = 0; i < N; i++) x_fwd[i] = 1;
    load_fwd();
    abort_run(50);
    load_fwd();
    run(1'b0, 1'b0, nbusy);
    for (int i = 0; i < N; i++) exp_v[i] = (i == 0) ? 1 : 0;
    readback("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ntt_inverse.md
Name: ntt_inverse

Overview:
- Inverse NTT engine for the polynomial pipeline; undoes ntt_forward so that ntt_inverse(ntt_forward(x)) == x.
- Uses radix-2 Gentleman-Sande (DIT-in / natural-out) butterflies, PARALLEL per cycle, on an internal N-word register file, followed by a final N^-1 scaling pass.
- Load/start/read interface mirrors ntt_forward, so the two blocks are interchangeable to a host sequencer.

Parameters:
- N, 256, transform size (power of 2).
- WIDTH, 32, coefficient word width.
- Q, 8380417, modulus.
- ADDR_WIDTH, 8, log2(N).
- REDUCTION_TYPE, 0, modular multiplier style: 0=simple, 1=Barrett, 2=Montgomery. Results must be bit-identical across all values.
- PARALLEL, 8, butterflies per cycle; must divide N/2.
- N_INV, 8347681, N^-1 mod Q (256*8347681 ≡ 1 mod 8380417).

Ports:
- clk, input, 1: clock. One clock domain only.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: begin transform; sampled only in IDLE.
- done, output, 1: one-cycle pulse when results are valid.
- busy, output, 1: high during COMPUTE and SCALE.
- load_coeff, input, 1: write enable; ignored while busy.
- load_addr, input, ADDR_WIDTH: load address.
- load_data, input, WIDTH: load data; must be < Q.
- read_addr, input, ADDR_WIDTH: read address.
- read_data, output, WIDTH: registered read data, one-cycle latency.

Behaviour:
- Reset (async): FSM=IDLE, busy=0, done=0, read_data=0, counters=0. Memory is not reset; it powers up zero. Reset mid-transform aborts immediately; memory then holds partial data.
- FSM states IDLE -> COMPUTE -> SCALE -> FIN -> IDLE.
  - IDLE: start=1 moves to COMPUTE at the next edge.
  - COMPUTE: runs LOGN stages x N/(2*PARALLEL) cycles, i.e. 128 cycles at defaults.
  - SCALE: N/(2*PARALLEL) cycles, i.e. 16 at defaults.
  - FIN: one cycle with done=1 and busy=0, then returns to IDLE.
- Latency at defaults: busy is high for exactly 144 consecutive cycles starting the cycle after the start edge; done is high in the following cycle.
- start while busy or in FIN: ignored. load_coeff while busy: ignored. Loads are accepted in IDLE and FIN.
- Stage t = 0..LOGN-1:
  - half = 1<<t; butterfly index b = base + lane.
  - group = b>>t; pos = b & (half-1).
  - addr0 = group*2*half + pos; addr1 = addr0 + half.
  - base advances by PARALLEL each cycle and wraps to 0 at N/2 while t increments.
- Twiddle: with s = LOGN-1-t, w = Q - twiddle_rom(bit_reverse(2^s + group)). Use the same twiddle_rom as the forward path. If the ROM value is 0, w = 0, not Q.
- Butterfly (GS), inputs < Q:
  - a' = (a+b) mod Q.
  - b' = (((a-b) mod Q) * w) mod Q, with the subtraction taken non-negative.
  - Results are written back to addr0/addr1 in the same cycle (combinational read, registered write). All lanes touch disjoint addresses.
- SCALE cycle k: words 2*PARALLEL*k .. 2*PARALLEL*k+2*PARALLEL-1 are each replaced by (x*N_INV) mod Q.
- Reads:
  - read_data <= mem[read_addr] on every edge, in any state.
  - Reads while busy return in-flight values.
  - A read in the same cycle as a load to the same address returns the old value.
- All outputs stored in memory are < Q. Word widths beyond log2(Q) are zero.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> busy=0, done=0, read_data=0 immediately. Deassert, then read addr 5 -> 0.
- All-ones input (mem[i]=1 for all i), start -> busy high 144 cycles, done pulse 1 cycle. Read back: mem[0]=1, mem[1..255]=0 (inverse of the forward NTT of the unit impulse).
- Round trip: load x[i]=i*1000+7, run ntt_forward, copy its 256 outputs into ntt_inverse, start -> read back i*1000+7 at every i. Repeat for REDUCTION_TYPE=0,1,2 with identical results.
- Boundary values: x[i]=Q-1 for all i through the round trip -> all outputs Q-1; no word >= Q at any read during busy.
- Protocol: pulse start at busy cycles 3 and 143, and load_coeff addr 0 data 99 mid-run -> single 144-cycle run, mem[0] not 99. Load in the FIN cycle is accepted.
- Abort: assert rst at busy cycle 50 -> busy=0 at once, no done. Reload all-ones, start -> full 144-cycle run, impulse result as in scenario 2.
